// File: rtl/rca_div_ctrl_if.sv
// Start/busy/done handshake bundle between the ALU opcode decoder and the divider.
// The master modport drives the operands and start; the slave modport returns the results.
interface rca_div_ctrl_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/rca_div_ctrl.sv
// Unsigned 16-bit restoring divider: one shared ripple-borrow subtractor, 16 cycles per result (1 for divide by zero).
// No queueing: start is only sampled while idle, and requests that arrive while busy are dropped.

module rca_sub (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        bin,
  output logic [15:0] sub,
  output logic        bout
);
  logic [16:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < 16; i++) begin : g_fs
    logic diff_ab;
    assign diff_ab       = in0[i] ^ in1[i];
    assign sub[i]        = diff_ab ^ borrow[i];
    assign borrow[i + 1] = (~in0[i] & in1[i]) | (~diff_ab & borrow[i]);
  end

  assign bout = borrow[16];
endmodule

module rca_div_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  rca_div_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DZ   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] q_reg;
  logic [15:0] r_reg;
  logic [15:0] d_reg;
  logic [3:0]  cnt;
  logic        busy_reg;
  logic        done_reg;
  logic        dz_reg;
  logic [15:0] quot_reg;
  logic [15:0] rem_reg;

  logic [16:0] shifted;
  logic [15:0] sub_val;
  logic        sub_bout;
  logic        take;
  logic [15:0] r_next;
  logic [15:0] q_next;

  assign shifted = {r_reg, q_reg[15]};

  rca_sub u_sub (
    .in0  (shifted[15:0]),
    .in1  (d_reg),
    .bin  (1'b0),
    .sub  (sub_val),
    .bout (sub_bout)
  );

  // A set bit 16 means the trial value already exceeds any 16-bit divisor; the wrapped difference is exact.
  assign take   = shifted[16] | ~sub_bout;
  assign r_next = take ? sub_val : shifted[15:0];
  assign q_next = {q_reg[14:0], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      quot_reg <= '0;
      rem_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_reg    <= bus.dividend;
            r_reg    <= '0;
            d_reg    <= bus.divisor;
            cnt      <= '0;
            busy_reg <= 1'b1;
            state    <= (bus.divisor == 16'd0) ? DZ : CALC;
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            quot_reg <= q_next;
            rem_reg  <= r_next;
            dz_reg   <= 1'b0;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        DZ: begin
          // q_reg still holds the captured dividend here.
          quot_reg <= 16'hFFFF;
          rem_reg  <= q_reg;
          dz_reg   <= 1'b1;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dz_reg;
endmodule
